// File: rtl/wb_project_mux_pkg.sv
// wb_project_mux_pkg
//   Shared types and constants for the multi-project Wishbone wrapper.
//   state_t       : bus FSM states (IDLE, FWD, CSR_ACK, ERR_ACK)
//   CSR_EN_BIT    : control register enable bit
//   CSR_ERR_BIT   : control register timeout sticky bit (write-1-to-clear)
//   ERR_DATA      : read data returned on an error ack
package wb_project_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD     = 2'd1,
    CSR_ACK = 2'd2,
    ERR_ACK = 2'd3
  } state_t;

  localparam int          CSR_EN_BIT  = 31;
  localparam int          CSR_ERR_BIT = 30;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter
//   Saturating cycle counter used to bound how long a forwarded access may
//   wait for a project ack.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (has priority over enable)
//   enable   : advance the count by one, saturating at TIMEOUT_CYCLES
//   expired  : count has reached TIMEOUT_CYCLES-1
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX   = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/wb_project_mux.sv
// wb_project_mux
//   Time-shares the user area among NUM_PROJECTS designs. A Wishbone CSR at
//   CSR_ADDR selects and enables one project; Wishbone, pad, LA and IRQ
//   traffic is routed only to/from that project. Forwarded accesses that are
//   not acked within TIMEOUT_CYCLES end with an error ack (ERR_DATA).
//   Host bus   : wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i -> wbs_ack_o/dat_o
//   Pads/LA    : io_in, la_data_in, la_oenb -> io_out, io_oeb, la_data_out
//   IRQ        : user_irq from the selected project
//   Projects   : proj_active_o (one-hot enable), proj_cyc_o/stb_o (gated),
//                proj_adr_o/dat_o/we_o/sel_o (broadcast), proj_ack_i/dat_i,
//                proj_io_out_i/io_oeb_i/la_out_i/irq_i (flattened, project k
//                at [k*W +: W]), proj_io_in_o/la_in_o/la_oenb_o (broadcast)
//   Debug      : dbg_state exposes the bus FSM state
//
// Handshake: a host request is cyc&stb. Every response is a single-cycle
// wbs_ack_o with wbs_dat_o valid in that same cycle; the host must drop stb
// after the ack, otherwise the held stb is decoded as a fresh access.
module wb_project_mux
  import wb_project_mux_pkg::*;
#(
  parameter int          NUM_PROJECTS   = 4,
  parameter int          SEL_W          = $clog2(NUM_PROJECTS),
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] CSR_ADDR       = 32'h3000_0000,
  parameter int          IO_W           = 38,
  parameter int          LA_W           = 32,
  parameter int          IRQ_W          = 3
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [IO_W-1:0]               io_in,
  output logic [IO_W-1:0]               io_out,
  output logic [IO_W-1:0]               io_oeb,
  input  logic [LA_W-1:0]               la_data_in,
  input  logic [LA_W-1:0]               la_oenb,
  output logic [LA_W-1:0]               la_data_out,
  output logic [IRQ_W-1:0]              user_irq,
  output logic [NUM_PROJECTS-1:0]       proj_active_o,
  output logic [NUM_PROJECTS-1:0]       proj_cyc_o,
  output logic [NUM_PROJECTS-1:0]       proj_stb_o,
  output logic [31:0]                   proj_adr_o,
  output logic [31:0]                   proj_dat_o,
  output logic                          proj_we_o,
  output logic [3:0]                    proj_sel_o,
  input  logic [NUM_PROJECTS-1:0]       proj_ack_i,
  input  logic [NUM_PROJECTS*32-1:0]    proj_dat_i,
  input  logic [NUM_PROJECTS*IO_W-1:0]  proj_io_out_i,
  input  logic [NUM_PROJECTS*IO_W-1:0]  proj_io_oeb_i,
  input  logic [NUM_PROJECTS*LA_W-1:0]  proj_la_out_i,
  input  logic [NUM_PROJECTS*IRQ_W-1:0] proj_irq_i,
  output logic [IO_W-1:0]               proj_io_in_o,
  output logic [LA_W-1:0]               proj_la_in_o,
  output logic [LA_W-1:0]               proj_la_oenb_o,
  output state_t                        dbg_state
);

  state_t state_q, state_d;

  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic             err_q;

  logic             enabled;
  logic [SEL_W-1:0] sel_idx;
  logic             proj_ack_sel;
  logic [31:0]      proj_dat_sel;
  logic [31:0]      csr_rd;
  logic             csr_wr;
  logic             err_set;
  logic             cnt_clear;
  logic             cnt_en;
  logic             expired;
  logic             cyc_stb;
  logic             csr_hit;

  // Out-of-range selects are kept in the register but treated as disabled.
  // sel_idx is forced to 0 in that case so every slice below stays in range.
  assign enabled = en_q && ({1'b0, sel_q} < (SEL_W + 1)'(NUM_PROJECTS));
  assign sel_idx = enabled ? sel_q : '0;

  assign proj_ack_sel = proj_ack_i[sel_idx];
  assign proj_dat_sel = proj_dat_i[sel_idx*32 +: 32];

  assign cyc_stb = wbs_cyc_i & wbs_stb_i;
  assign csr_hit = (wbs_adr_i == CSR_ADDR);

  assign proj_active_o = enabled ? ({{(NUM_PROJECTS-1){1'b0}}, 1'b1} << sel_idx)
                                 : '0;

  // Broadcast request and input copies.
  assign proj_adr_o     = wbs_adr_i;
  assign proj_dat_o     = wbs_dat_i;
  assign proj_we_o      = wbs_we_i;
  assign proj_sel_o     = wbs_sel_i;
  assign proj_io_in_o   = io_in;
  assign proj_la_in_o   = la_data_in;
  assign proj_la_oenb_o = la_oenb;

  assign dbg_state = state_q;

  always_comb begin
    csr_rd              = '0;
    csr_rd[SEL_W-1:0]   = sel_q;
    csr_rd[CSR_ERR_BIT] = err_q;
    csr_rd[CSR_EN_BIT]  = en_q;
  end

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The decode cycle in IDLE already counts toward the timeout, so the error
  // ack lands in cycle TIMEOUT_CYCLES+1 of the strobe.
  always_comb begin
    state_d    = state_q;
    wbs_ack_o  = 1'b0;
    wbs_dat_o  = '0;
    proj_cyc_o = '0;
    proj_stb_o = '0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    csr_wr     = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cyc_stb) begin
          cnt_en = 1'b1;
          if (csr_hit)      state_d = CSR_ACK;
          else if (enabled) state_d = FWD;
          else              state_d = ERR_ACK;
        end else begin
          cnt_clear = 1'b1;
        end
      end
      FWD: begin
        proj_cyc_o[sel_idx] = wbs_cyc_i;
        proj_stb_o[sel_idx] = wbs_stb_i;
        wbs_dat_o           = proj_dat_sel;
        wbs_ack_o           = wbs_cyc_i & proj_ack_sel;
        if (!wbs_cyc_i || proj_ack_sel) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end else if (expired) begin
          state_d = ERR_ACK;
        end else begin
          cnt_en = 1'b1;
        end
      end
      CSR_ACK: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = csr_rd;
        csr_wr    = wbs_cyc_i & wbs_we_i;
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
      ERR_ACK: begin
        wbs_ack_o = 1'b1;
        wbs_dat_o = ERR_DATA;
        err_set   = 1'b1;
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky set takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sel_q <= '0;
      en_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (csr_wr && wbs_sel_i[0]) sel_q <= wbs_dat_i[SEL_W-1:0];
      if (csr_wr && wbs_sel_i[3]) en_q  <= wbs_dat_i[CSR_EN_BIT];
      if (err_set) begin
        err_q <= 1'b1;
      end else if (csr_wr && wbs_sel_i[3] && wbs_dat_i[CSR_ERR_BIT]) begin
        err_q <= 1'b0;
      end
    end
  end

  // Pad/LA/IRQ mux; a disabled core parks the pads as inputs.
  always_comb begin
    io_out      = '0;
    io_oeb      = '1;
    la_data_out = '0;
    user_irq    = '0;
    if (enabled) begin
      io_out      = proj_io_out_i[sel_idx*IO_W +: IO_W];
      io_oeb      = proj_io_oeb_i[sel_idx*IO_W +: IO_W];
      la_data_out = proj_la_out_i[sel_idx*LA_W +: LA_W];
      user_irq    = proj_irq_i[sel_idx*IRQ_W +: IRQ_W];
    end
  end

endmodule

// File: tb/tb_wb_project_mux.sv
module tb_wb_project_mux;
  import wb_project_mux_pkg::*;

  localparam int N     = 4;
  localparam int IO_W  = 38;
  localparam int LA_W  = 32;
  localparam int IRQ_W = 3;

  // ---------------- clock / reset ----------------
  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [IO_W-1:0]   io_in, io_out, io_oeb;
  logic [LA_W-1:0]   la_data_in, la_oenb, la_data_out;
  logic [IRQ_W-1:0]  user_irq;
  logic [N-1:0]      proj_active_o, proj_cyc_o, proj_stb_o, proj_ack_i;
  logic [31:0]       proj_adr_o, proj_dat_o;
  logic              proj_we_o;
  logic [3:0]        proj_sel_o;
  logic [N*32-1:0]   proj_dat_i;
  logic [N*IO_W-1:0] proj_io_out_i, proj_io_oeb_i;
  logic [N*LA_W-1:0] proj_la_out_i;
  logic [N*IRQ_W-1:0] proj_irq_i;
  logic [IO_W-1:0]   proj_io_in_o;
  logic [LA_W-1:0]   proj_la_in_o, proj_la_oenb_o;
  state_t            dbg_state;

  wb_project_mux dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
    .user_irq(user_irq), .proj_active_o(proj_active_o),
    .proj_cyc_o(proj_cyc_o), .proj_stb_o(proj_stb_o),
    .proj_adr_o(proj_adr_o), .proj_dat_o(proj_dat_o), .proj_we_o(proj_we_o),
    .proj_sel_o(proj_sel_o), .proj_ack_i(proj_ack_i), .proj_dat_i(proj_dat_i),
    .proj_io_out_i(proj_io_out_i), .proj_io_oeb_i(proj_io_oeb_i),
    .proj_la_out_i(proj_la_out_i), .proj_irq_i(proj_irq_i),
    .proj_io_in_o(proj_io_in_o), .proj_la_in_o(proj_la_in_o),
    .proj_la_oenb_o(proj_la_oenb_o), .dbg_state(dbg_state)
  );

  // ---------------- project models ----------------
  // lat[k] < 0 means the project never acks; otherwise it acks on the
  // (lat+1)-th consecutive cycle its strobe is high.
  int               lat  [N];
  int               pcnt [N];
  logic [31:0]      pdat [N];
  logic [IO_W-1:0]  pio  [N];
  logic [IO_W-1:0]  poeb [N];
  logic [LA_W-1:0]  pla  [N];
  logic [IRQ_W-1:0] pirq [N];

  always_ff @(posedge wb_clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (wb_rst_i || !proj_stb_o[k] || proj_ack_i[k]) pcnt[k] <= 0;
      else                                              pcnt[k] <= pcnt[k] + 1;
    end
  end

  always_comb begin
    proj_ack_i    = '0;
    proj_dat_i    = '0;
    proj_io_out_i = '0;
    proj_io_oeb_i = '0;
    proj_la_out_i = '0;
    proj_irq_i    = '0;
    for (int k = 0; k < N; k++) begin
      proj_ack_i[k]                 = proj_stb_o[k] && (lat[k] >= 0) && (pcnt[k] == lat[k]);
      proj_dat_i[k*32 +: 32]        = pdat[k];
      proj_io_out_i[k*IO_W +: IO_W] = pio[k];
      proj_io_oeb_i[k*IO_W +: IO_W] = poeb[k];
      proj_la_out_i[k*LA_W +: LA_W] = pla[k];
      proj_irq_i[k*IRQ_W +: IRQ_W]  = pirq[k];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_csr;
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdat, output int cycles, output logic acked,
                           output logic [3:0] stb_seen, output logic [3:0] act_at_ack);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    cycles = 0; acked = 1'b0; stb_seen = '0; rdat = '0; act_at_ack = '0;
    while (!acked && cycles < budget) begin
      @(negedge wb_clk_i);
      cycles++;
      stb_seen |= proj_stb_o;
      if (wbs_ack_o) begin
        acked      = 1'b1;
        rdat       = wbs_dat_o;
        act_at_ack = proj_active_o;
      end
    end
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic bus_op(input string tag, input logic [31:0] adr, input logic we,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_data, input int exp_cycles,
                        input logic [3:0] exp_stb, output logic [3:0] act_at_ack);
    logic [31:0] rdat;
    int          cycles;
    logic        acked;
    logic [3:0]  stb_seen;
    exp_q.push_back(exp_data);
    wb_access(adr, we, dat, sel, exp_cycles + 20, rdat, cycles, acked, stb_seen, act_at_ack);
    check({tag, "_ack"}, acked, 1'b1);
    check({tag, "_dat"}, rdat, exp_q.pop_front());
    check({tag, "_lat"}, cycles, exp_cycles);
    check({tag, "_stb"}, stb_seen, exp_stb);
  endtask

  task automatic csr_read(input string tag);
    logic [3:0] a;
    bus_op(tag, 32'h3000_0000, 1'b0, 32'h0, 4'hF, exp_csr, 2, 4'b0000, a);
  endtask

  task automatic csr_write(input string tag, input logic [31:0] dat, input logic [3:0] sel,
                           output logic [3:0] act_at_ack);
    bus_op(tag, 32'h3000_0000, 1'b1, dat, sel, exp_csr, 2, 4'b0000, act_at_ack);
    if (sel[0]) exp_csr[1:0] = dat[1:0];
    if (sel[3]) begin
      exp_csr[31] = dat[31];
      if (dat[30]) exp_csr[30] = 1'b0;
    end
  endtask

  task automatic check_pads(input string tag, input int k);
    check({tag, "_io"},  io_out,      pio[k]);
    check({tag, "_oeb"}, io_oeb,      poeb[k]);
    check({tag, "_la"},  la_data_out, pla[k]);
    check({tag, "_irq"}, user_irq,    pirq[k]);
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_act"}, proj_active_o, 4'b0000);
    check({tag, "_io"},  io_out,        {IO_W{1'b0}});
    check({tag, "_oeb"}, io_oeb,        38'h3F_FFFF_FFFF);
    check({tag, "_la"},  la_data_out,   {LA_W{1'b0}});
    check({tag, "_irq"}, user_irq,      {IRQ_W{1'b0}});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0]  a;
    logic [31:0] rd;
    int          l;

    wb_rst_i = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    io_in = 38'({$urandom(), $urandom()});
    la_data_in = $urandom(); la_oenb = $urandom();
    for (int k = 0; k < N; k++) begin
      lat[k]  = -1;
      pdat[k] = $urandom();
      pio[k]  = 38'({$urandom(), $urandom()});
      poeb[k] = 38'({$urandom(), $urandom()});
      pla[k]  = $urandom();
      pirq[k] = 3'($urandom_range(7, 0));
    end
    exp_csr = 32'h0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state
    @(negedge wb_clk_i);
    check_parked("rst");
    check("rst_ack",   wbs_ack_o,  1'b0);
    check("rst_dat",   wbs_dat_o,  32'h0);
    check("rst_stb",   proj_stb_o, 4'b0000);
    check("rst_state", dbg_state,  IDLE);
    check("rst_ioin",  proj_io_in_o, io_in);
    csr_read("rst_csr");

    // Select project 2 and forward
    csr_write("en_p2", 32'h8000_0002, 4'hF, a);
    @(negedge wb_clk_i);
    check("en_p2_act", proj_active_o, 4'b0100);
    check_pads("en_p2", 2);
    lat[2] = 3; pdat[2] = 32'h1234_5678;
    bus_op("fwd_p2", 32'h3000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 5, 4'b0100, a);
    lat[2] = 0;
    bus_op("fwd_wr", 32'h3000_0020, 1'b1, 32'hA5A5_0001, 4'hF, pdat[2], 2, 4'b0100, a);

    // Timeout
    lat[2] = -1;
    bus_op("tmo", 32'h3000_0010, 1'b0, 32'h0, 4'hF, ERR_DATA, 256, 4'b0100, a);
    exp_csr[30] = 1'b1;
    csr_read("tmo_csr");
    csr_write("w1c", 32'hC000_0002, 4'hF, a);
    csr_read("w1c_csr");

    // Disabled access
    csr_write("dis", 32'h0000_0002, 4'b1000, a);
    @(negedge wb_clk_i);
    check_parked("dis");
    bus_op("dis_rd", 32'h3000_0040, 1'b0, 32'h0, 4'hF, ERR_DATA, 2, 4'b0000, a);
    exp_csr[30] = 1'b1;
    csr_read("dis_csr");

    // Abort and switch
    csr_write("reen", 32'h8000_0002, 4'b1001, a);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0050; wbs_sel_i = 4'hF;
    repeat (9) @(negedge wb_clk_i);
    check("abort_pre_stb",   proj_stb_o, 4'b0100);
    check("abort_pre_state", dbg_state,  FWD);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge wb_clk_i);
    check("abort_ack", wbs_ack_o, 1'b0);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check("abort_stb",   proj_stb_o, 4'b0000);
    check("abort_state", dbg_state,  IDLE);
    csr_write("sw_p1", 32'h8000_0001, 4'b1001, a);
    check("sw_act_old", a, 4'b0100);
    @(negedge wb_clk_i);
    check("sw_act_new", proj_active_o, 4'b0010);
    check_pads("sw_p1", 1);

    // Randomised forwarding on project 1
    for (int i = 0; i < 4; i++) begin
      l = $urandom_range(6, 0);
      lat[1]  = l;
      pdat[1] = $urandom();
      bus_op("rnd", 32'h3000_0100 + 32'(i * 4), 1'b0, 32'h0, 4'hF, pdat[1], l + 2, 4'b0010, a);
    end

    // Reset mid-access
    lat[1] = -1;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = 32'h3000_0200;
    repeat (4) @(negedge wb_clk_i);
    @(posedge wb_clk_i); #1 wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rstmid_ack0", wbs_ack_o, 1'b0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge wb_clk_i);
    check_parked("rstmid");
    check("rstmid_ack",   wbs_ack_o,  1'b0);
    check("rstmid_dat",   wbs_dat_o,  32'h0);
    check("rstmid_stb",   proj_stb_o, 4'b0000);
    check("rstmid_state", dbg_state,  IDLE);
    exp_csr = 32'h0;
    csr_read("rstmid_csr");

    // ---------------- final report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_project_mux.md
# wb_project_mux

Parametrised multi-project wrapper core that time-shares the Caravel user area among `NUM_PROJECTS` user designs (SHA-1 and successors). It owns a Wishbone CSR that selects and enables one project, routes Wishbone, IO, logic-analyzer and IRQ traffic to and from that project only, and guards the bus with a timeout that returns an error pattern instead of hanging the management SoC. It sits directly under `user_project_wrapper`, with the projects instantiated beside it.

## Interface

Parameters:
- `NUM_PROJECTS`, 4: number of attached projects, 2..16.
- `SEL_W`, `$clog2(NUM_PROJECTS)`: select field width.
- `TIMEOUT_CYCLES`, 255: cycles to wait for a project ack, at least 2.
- `CSR_ADDR`, 32'h3000_0000: word address of the control register.
- `IO_W`, 38; `LA_W`, 32; `IRQ_W`, 3: per-project IO, LA and IRQ widths.

Ports:
- `wb_clk_i` in 1: the single clock. Reset is synchronous and active-high (`wb_rst_i`).
- `wb_rst_i` in 1: synchronous, active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1; `wbs_sel_i` in 4; `wbs_adr_i`, `wbs_dat_i` in 32: host Wishbone request.
- `wbs_ack_o` out 1; `wbs_dat_o` out 32: host Wishbone response.
- `io_in` in IO_W; `io_out`, `io_oeb` out IO_W: pads.
- `la_data_in`, `la_oenb` in LA_W; `la_data_out` out LA_W: logic analyzer.
- `user_irq` out IRQ_W: interrupts.
- `proj_active_o` out N: one-hot enable to each project.
- `proj_cyc_o`, `proj_stb_o` out N: per-project gated strobes.
- `proj_adr_o`, `proj_dat_o` out 32; `proj_we_o` out 1; `proj_sel_o` out 4: broadcast request.
- `proj_ack_i` in N; `proj_dat_i` in N*32: project responses, flattened with project k at `[k*32 +: 32]`.
- `proj_io_out_i`, `proj_io_oeb_i` in N*IO_W; `proj_la_out_i` in N*LA_W; `proj_irq_i` in N*IRQ_W: project outputs, flattened.
- `proj_io_in_o` out IO_W; `proj_la_in_o`, `proj_la_oenb_o` out LA_W: broadcast copies of the pad and LA inputs.

## Operation

- **CSR layout:**
  - `[SEL_W-1:0]` select, read/write.
  - `[30]` timeout sticky, write-1-to-clear.
  - `[31]` enable.
  - Other bits read as 0.
- **Select range:** select values ≥ NUM_PROJECTS are stored as written, but the core then behaves as disabled.
- **FSM states:** IDLE, FWD, CSR_ACK, ERR_ACK.
  - **IDLE:**
    - `cyc&stb` with `adr==CSR_ADDR` → CSR_ACK.
    - Otherwise `cyc&stb` with the core enabled → FWD.
    - Otherwise `cyc&stb` with the core disabled → ERR_ACK.
  - **FWD:**
    - `proj_cyc_o[sel]`/`proj_stb_o[sel]` follow the host; the other projects' strobes are 0.
    - `wbs_ack_o = proj_ack_i[sel]` and `wbs_dat_o = proj_dat_i[sel]`, combinationally; on ack → IDLE.
    - When the wait counter reaches TIMEOUT_CYCLES−1 without an ack → ERR_ACK, and the project strobe drops.
    - `wbs_cyc_i` low → IDLE, counter cleared.
  - **CSR_ACK:**
    - Registered `wbs_ack_o=1`, `wbs_dat_o` = CSR readback.
    - A write is applied on this cycle, byte lane 0 for select and lane 3 for enable/W1C → IDLE.
  - **ERR_ACK:** `wbs_ack_o=1`, `wbs_dat_o=32'hDEAD_BEEF`, timeout sticky set → IDLE.
- **Routing:**
  - `proj_active_o = enabled ? onehot(sel) : 0`.
  - `io_out`, `io_oeb`, `la_data_out` and `user_irq` come from the selected project.
  - While disabled: `io_oeb` is all 1, `io_out`, `la_data_out` and `user_irq` are 0.
- **Simultaneous events:** a W1C of the sticky in the same cycle as an ERR_ACK leaves the sticky set (set wins).

## Timing

- **Reset values:** state IDLE, select 0, enable 0, sticky 0, `wbs_ack_o` 0, `wbs_dat_o` 0, `proj_active_o` 0, all project strobes 0, `io_oeb` all 1, `io_out`/`la_data_out`/`user_irq` 0.
- **Reset mid-transaction:** all state is dropped at the next edge, with no ack issued.
- **CSR access latency:** ack in the 2nd cycle of the strobe.
- **Disabled access latency:** ack in the 2nd cycle of the strobe.
- **Project access latency:** project latency + 1 (the first cycle is decode).
- **Timeout:** error ack in cycle TIMEOUT_CYCLES+1 after the strobe.
- **Ack width:** every ack is exactly one cycle. The host must drop `stb` after an ack; a held `stb` starts a new access from IDLE.
- **Select/enable changes:** take effect the cycle after the CSR_ACK, so `proj_active_o` switches atomically between projects with no overlap. The pad mux switches in that same cycle.

## Structure

- **Package `wb_project_mux_pkg`:**
  - `state_t` enum.
  - CSR bit indices (`CSR_EN_BIT=31`, `CSR_ERR_BIT=30`).
  - `ERR_DATA=32'hDEAD_BEEF`.
- **Sub-module `wb_timeout_counter`:** clear/enable inputs, `expired` output, width `$clog2(TIMEOUT_CYCLES+1)`, saturating.
- The pad and LA muxes are plain indexed slices in the top module.

## Test plan

- **Reset:** reset → `io_oeb=38'h3F_FFFF_FFFF`, `proj_active_o=0`, CSR read returns 0.
- **Select and forward:** write CSR `32'h8000_0002`, then read `0x3000_0010` with project 2 acking after 3 cycles with `32'h1234_5678` → host gets `32'h1234_5678` on cycle 5. `proj_stb_o=4'b0100` during the access, and `proj_active_o=4'b0100`.
- **Timeout:** project 2 never acks → `wbs_dat_o=32'hDEAD_BEEF` on cycle 256 and the CSR reads `32'hC000_0002`. Writing `32'hC000_0002` clears bit 30.
- **Disabled access:** enable=0, any non-CSR read → error ack on cycle 2, no `proj_stb_o` asserted.
- **Abort and switch:** host drops `cyc` in FWD at cycle 10 → `proj_stb_o=0` on the next edge and the state is IDLE. Then write select 1 → `proj_active_o` goes 0100 → 0010 in one cycle, and `io_out` tracks project 1.
- **Reset mid-access:** `wb_rst_i` asserted mid-FWD → no ack issued, all outputs at reset values the next cycle.
